// File: rtl/uart_rcv_fifo.sv
// UART receiver with configurable frame format feeding a first-word-fall-through FIFO
// with per-entry error flags. Define UART_RCV_BREAK_DETECT_EN to enable break detection.
module uart_rcv_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int BUS_W        = 32
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          RxD,
  input  logic                          RD,
  input  logic                          ClrErr,
  output logic [BUS_W-1:0]              Dout,
  output logic                          RxRDY,
  output logic                          RxParityErr,
  output logic                          RxFrameErr,
  output logic                          RxOverrun,
  output logic                          RxBreak,
  output logic [$clog2(FIFO_DEPTH):0]   FifoCount
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
  localparam logic          ODD       = (PARITY == 2);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_WAITHI
  } state_e;

  // Synchroniser resets to the idle level so release of reset never looks like a start edge.
  logic rx_meta_q, rxs_q, rxs_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= RxD;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bit_q;
  logic                   stop_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   par_bit_q;
  logic                   frame_err_q;
  logic                   push_q;
  logic [EW-1:0]          push_data_q;
`ifdef UART_RCV_BREAK_DETECT_EN
  logic                   break_set_q;
`endif

  logic half_hit, full_hit, par_err_c, all_zero_c;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    half_hit   = 1'b0;
    full_hit   = 1'b0;
    par_err_c  = 1'b0;
    all_zero_c = 1'b0;
    half_hit   = (cnt_q == HALF_LAST);
    full_hit   = (cnt_q == FULL_LAST);
    par_err_c  = (PARITY != 0) && ((^shreg_q ^ par_bit_q) != ODD);
    all_zero_c = (shreg_q == '0) && !par_bit_q && !rxs_q && !stop_q;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      shreg_q     <= '0;
      par_bit_q   <= 1'b0;
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
`ifdef UART_RCV_BREAK_DETECT_EN
      break_set_q <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
`ifdef UART_RCV_BREAK_DETECT_EN
      break_set_q <= 1'b0;
`endif
      cnt_q <= full_hit ? '0 : cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (rxs_prev_q && !rxs_q) state_q <= S_START;
        end
        S_START: begin
          if (half_hit) begin
            cnt_q       <= '0;
            bit_q       <= '0;
            stop_q      <= 1'b0;
            par_bit_q   <= 1'b0;
            frame_err_q <= 1'b0;
            state_q     <= rxs_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (full_hit) begin
            shreg_q <= {rxs_q, shreg_q[DATA_BITS-1:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == BIT_LAST) state_q <= (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
        S_PAR: begin
          if (full_hit) begin
            par_bit_q <= rxs_q;
            state_q   <= S_STOP;
          end
        end
        S_STOP: begin
          if (full_hit) begin
            if (all_zero_c) begin
              // An all-zero frame is judged on the first stop sample.
`ifdef UART_RCV_BREAK_DETECT_EN
              break_set_q <= 1'b1;
`else
              push_q      <= 1'b1;
              push_data_q <= {1'b1, par_err_c, shreg_q};
`endif
              state_q <= S_WAITHI;
            end else if (stop_q == STOP_LAST) begin
              push_q      <= 1'b1;
              push_data_q <= {frame_err_q | !rxs_q, par_err_c, shreg_q};
              state_q     <= rxs_q ? S_IDLE : S_WAITHI;
            end else begin
              stop_q      <= stop_q + 1'b1;
              frame_err_q <= frame_err_q | !rxs_q;
            end
          end
        end
        S_WAITHI: begin
          cnt_q <= '0;
          if (rxs_q) state_q <= S_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          pop, full, do_push;
  logic [EW-1:0] head;

  always_comb begin
    pop       = RD && (count_q != '0);
    full      = (count_q == DEPTH_C);
    do_push   = push_q && (!full || pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !do_push) count_d = count_q - 1'b1;
    // A set on the same edge wins over ClrErr.
    if (push_q && full && !pop) overrun_d = 1'b1;
    else if (ClrErr)            overrun_d = 1'b0;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the count gates every read of it.
  always_ff @(posedge Clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_q;
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    Dout        = '0;
    RxParityErr = 1'b0;
    RxFrameErr  = 1'b0;
    if (count_q != '0) begin
      Dout[DATA_BITS-1:0] = head[DATA_BITS-1:0];
      RxParityErr         = head[DATA_BITS];
      RxFrameErr          = head[DATA_BITS+1];
    end
  end

  assign RxRDY     = (count_q != '0);
  assign RxOverrun = overrun_q;
  assign FifoCount = count_q;

`ifdef UART_RCV_BREAK_DETECT_EN
  logic break_q, break_d;

  always_comb begin
    break_d = break_q;
    if (break_set_q) break_d = 1'b1;
    else if (ClrErr) break_d = 1'b0;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) break_q <= 1'b0;
    else        break_q <= break_d;
  end

  assign RxBreak = break_q;
`else
  assign RxBreak = 1'b0;
`endif

endmodule

// File: doc/uart_rcv_fifo.md
Name: uart_rcv_fifo

Overview:
- Parametrised UART receiver for the 32-bit CPU peripheral bus.
- Generalises the fixed-format receiver with:
  - configurable data width, parity mode, stop-bit count and baud divisor;
  - a first-word-fall-through receive FIFO with per-entry error flags;
  - sticky overrun reporting.
- Sits between the RxD pin and the CPU load path, read through the RD strobe.

Parameters:
- CLKS_PER_BIT, 16: Clock cycles per bit period. Must be ≥4 and even.
- DATA_BITS, 8: Data bits per frame, 5..9. Sent LSB first.
- PARITY, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: Receive FIFO entries. Power of 2, ≥2.
- BUS_W, 32: Width of Dout.

Ports:
- Clock  in  1  System clock. All logic on rising edge.
- Reset  in  1  Asynchronous, active-low reset.
- RxD  in  1  Serial input. Asynchronous; idles high.
- RD  in  1  Read strobe. A 1-cycle pulse pops the FIFO head.
- ClrErr  in  1  Clears the sticky RxOverrun and RxBreak.
- Dout  out  BUS_W  Head data, zero-extended. Zero when the FIFO is empty.
- RxRDY  out  1  FIFO non-empty.
- RxParityErr  out  1  Parity-error flag of the head entry.
- RxFrameErr  out  1  Framing-error flag of the head entry.
- RxOverrun  out  1  Sticky. A frame was dropped because the FIFO was full.
- RxBreak  out  1  Sticky break indication. See Optional Feature.
- FifoCount  out  clog2(FIFO_DEPTH)+1  Number of entries in the FIFO.

Behaviour:
- Reset (Reset=0, asynchronous):
  - FSM goes to IDLE; baud counter, shift register, FIFO pointers and all sticky flags clear.
  - All outputs are 0.
  - Applies mid-frame too: a partial frame is discarded.
- Input synchroniser: RxD passes through a 2-FF synchroniser to give rxs. All sampling uses rxs.
- Baud counter: counts 0..CLKS_PER_BIT-1 and restarts on every state entry. "Mid-bit" is count == CLKS_PER_BIT/2-1.
- FSM states: IDLE, START, DATA, PAR, STOP, WAITHI.
  - IDLE: a high-to-low transition of rxs enters START.
  - START: at the half-bit point, rxs=1 is a false start and returns to IDLE with nothing recorded. rxs=0 re-zeroes the counter and enters DATA.
  - DATA:
    - Samples rxs at each full bit period after the start midpoint and shifts it in LSB first.
    - After DATA_BITS samples, goes to PAR if PARITY≠0, else to STOP.
  - PAR:
    - Samples the parity bit.
    - Parity error if the XOR of data bits and parity bit is ≠0 (even mode) or ≠1 (odd mode).
  - STOP:
    - Samples STOP_BITS stop bits, one bit period apart.
    - Any low stop sample is a framing error.
    - On the last stop sample, pushes {frame_err, par_err, data} to the FIFO and goes to IDLE if rxs=1, else WAITHI.
  - WAITHI: waits for rxs=1, then IDLE. A held-low line never retriggers a start.
- Latency: RxRDY rises 1 cycle after the last stop-bit sample clock edge.
- FIFO:
  - First-word fall-through. Dout and the error flags show the head entry combinationally from the registered storage.
  - RD with RxRDY=1 pops on that edge. RD while empty is ignored.
  - Push while full and no RD: the frame is dropped, RxOverrun←1 and the FIFO is unchanged.
  - Push and RD on the same edge with the FIFO full: both occur, FifoCount is unchanged, no overrun.
  - Push and RD on the same edge with the FIFO empty: the push is retained and the RD is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: ClrErr=1 clears them on the next edge. A set event on the same edge takes priority over the clear.

Optional Feature:
- Macro: UART_RCV_BREAK_DETECT_EN.
- Defined:
  - A frame whose data bits, parity bit (if any) and first stop bit all sample 0 is a break.
  - A break sets RxBreak (sticky), is not pushed to the FIFO, and the FSM goes to WAITHI.
- Undefined:
  - RxBreak is tied to 0.
  - Such a frame is pushed as data 0 with RxFrameErr=1, then the FSM goes to WAITHI.

Test Plan:

Unless stated, CLKS_PER_BIT=16, DATA_BITS=8, PARITY=1, STOP_BITS=1, FIFO_DEPTH=4.

1. Send 0xA5, parity bit 0, stop 1 → after the stop-bit sample, RxRDY=1, Dout=0x000000A5, RxParityErr=0, RxFrameErr=0, FifoCount=1. Pulse RD for 1 cycle → RxRDY=0, Dout=0.
2. Send 0x3C with parity bit 1 → Dout=0x0000003C, RxParityErr=1. Then send 0x3C with parity bit 0 and pop the first entry → RxParityErr=0 for the new head.
3. Drive RxD low for 5 clocks, then high → no entry written, FSM back in IDLE, FifoCount=0. Next frame 0x81 is received correctly.
4. Send 0x01..0x05 with no reads → FifoCount=4 and RxOverrun=1. Reads return 0x01, 0x02, 0x03, 0x04. ClrErr → RxOverrun=0.
5. Send 0x55 with stop bit 0, then hold RxD low for 3 bit periods → entry 0x55 with RxFrameErr=1, no further frames. Release RxD high, send 0x0F → second entry 0x0F.
6. Assert Reset during data bit 3 → all outputs 0 immediately. Deassert, send 0x81 → Dout=0x00000081. With UART_RCV_BREAK_DETECT_EN, an all-zero frame → RxBreak=1 and FifoCount unchanged.
